// File: rtl/mii_pkg.sv
// Shared constants and types for the MII command receive path.
package mii_pkg;

  localparam logic [31:0] CRC_POLY    = 32'hedb88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;
  localparam logic [31:0] CRC_INIT    = 32'hffffffff;

  localparam logic [11:0] MIN_NIBBLES = 12'd128;
  localparam logic [11:0] MAX_NIBBLES = 12'd3036;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    PRE       = 3'd2,
    BODY      = 3'd3,
    DROP      = 3'd4
  } rx_state_t;

endpackage

// File: rtl/mii_crc32.sv
// Reflected CRC-32 register advancing one nibble (LSB first) per enabled cycle.
module mii_crc32
  import mii_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [3:0]  data,
  output logic [31:0] crc
);

  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 4; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[31:1]} ^ (fb ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc_nibble(crc, data);
    end
  end

endmodule

// File: rtl/mii_cmd_rx.sv
// MII receive deframer: address/type/length/FCS checks and command field capture.
module mii_cmd_rx
  import mii_pkg::*;
#(
  parameter logic [47:0] MAC       = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h5555
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mii_D,
  input  logic        mii_DV,
  input  logic        mii_ER,
  output logic [19:0] command,
  output logic [2:0]  opcode,
  output logic [7:0]  seqnum,
  output logic        strobe,
  output logic        tx_strobe,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  rx_state_t   state;
  logic [11:0] nib_cnt;
  logic [3:0]  low_nib;
  logic        seen_pre;
  logic        not_mac;
  logic        not_bcast;
  logic        type_bad;
  logic [7:0]  seq_sh;
  logic [2:0]  op_sh;
  logic [19:0] cmd_sh;
  logic        strobe_d1;
  logic [31:0] crc;

  logic [10:0] byte_idx;
  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        body_nib;
  logic        sfd;
  logic        verdict;
  logic        accept;
  logic        drop_end;
  logic [7:0]  mac_byte;

  assign byte_idx  = nib_cnt[11:1];
  assign byte_done = nib_cnt[0];
  assign rx_byte   = {mii_D, low_nib};
  assign body_nib  = (state == BODY) && mii_DV && !mii_ER;
  assign sfd       = (state == PRE) && mii_DV && !mii_ER && (mii_D == 4'hd) && seen_pre;
  assign verdict   = (state == BODY) && !mii_DV;
  assign drop_end  = (state == DROP) && !mii_DV;
  assign accept    = verdict && !(not_mac && not_bcast) && !type_bad &&
                     (crc == CRC_RESIDUE) && (nib_cnt >= MIN_NIBBLES) &&
                     (nib_cnt <= MAX_NIBBLES) && !nib_cnt[0];

  always_comb begin
    mac_byte = 8'h00;
    case (byte_idx)
      11'd0:   mac_byte = MAC[47:40];
      11'd1:   mac_byte = MAC[39:32];
      11'd2:   mac_byte = MAC[31:24];
      11'd3:   mac_byte = MAC[23:16];
      11'd4:   mac_byte = MAC[15:8];
      11'd5:   mac_byte = MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  mii_crc32 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (sfd),
    .enable (body_nib),
    .data   (mii_D),
    .crc    (crc)
  );

  // The nibble sampled while leaving IDLE counts as preamble too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_IDLE;
      seen_pre <= 1'b0;
    end else begin
      case (state)
        WAIT_IDLE: if (!mii_DV) state <= IDLE;
        IDLE: begin
          if (mii_DV) begin
            state    <= PRE;
            seen_pre <= (mii_D == 4'h5) && !mii_ER;
          end
        end
        PRE: begin
          if (!mii_DV)                 state <= IDLE;
          else if (mii_ER)             state <= DROP;
          else if (mii_D == 4'h5)      seen_pre <= 1'b1;
          else if (sfd)                state <= BODY;
          else                         state <= DROP;
        end
        BODY: begin
          if (!mii_DV)     state <= IDLE;
          else if (mii_ER) state <= DROP;
        end
        DROP:    if (!mii_DV) state <= IDLE;
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_cnt   <= 12'd0;
      low_nib   <= 4'h0;
      not_mac   <= 1'b0;
      not_bcast <= 1'b0;
      type_bad  <= 1'b0;
      seq_sh    <= 8'h00;
      op_sh     <= 3'd0;
      cmd_sh    <= 20'h0;
    end else if (sfd) begin
      nib_cnt   <= 12'd0;
      low_nib   <= 4'h0;
      not_mac   <= 1'b0;
      not_bcast <= 1'b0;
      type_bad  <= 1'b0;
      seq_sh    <= 8'h00;
      op_sh     <= 3'd0;
      cmd_sh    <= 20'h0;
    end else if (body_nib) begin
      if (nib_cnt != 12'hfff) nib_cnt <= nib_cnt + 12'd1;
      if (!byte_done) begin
        low_nib <= mii_D;
      end else begin
        case (byte_idx)
          11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5: begin
            if (rx_byte != mac_byte) not_mac   <= 1'b1;
            if (rx_byte != 8'hff)    not_bcast <= 1'b1;
          end
          11'd12:  if (rx_byte != ETHERTYPE[15:8]) type_bad <= 1'b1;
          11'd13:  if (rx_byte != ETHERTYPE[7:0])  type_bad <= 1'b1;
          11'd14:  seq_sh <= rx_byte;
          11'd15:  op_sh <= rx_byte[2:0];
          11'd16:  cmd_sh[7:0] <= rx_byte;
          11'd17:  cmd_sh[15:8] <= rx_byte;
          11'd18:  cmd_sh[19:16] <= rx_byte[3:0];
          default: ;
        endcase
      end
    end
  end

  // tx_strobe trails strobe by two flops so the reply starts after data is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      command    <= 20'h0;
      opcode     <= 3'd0;
      seqnum     <= 8'h00;
      strobe     <= 1'b0;
      strobe_d1  <= 1'b0;
      tx_strobe  <= 1'b0;
      good_count <= 16'h0;
      bad_count  <= 16'h0;
    end else begin
      strobe_d1 <= strobe;
      tx_strobe <= strobe_d1;
      if (accept) begin
        command    <= cmd_sh;
        opcode     <= op_sh;
        seqnum     <= seq_sh;
        strobe     <= ~strobe;
        good_count <= good_count + 16'd1;
      end else if (verdict || drop_end) begin
        bad_count  <= bad_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mii_cmd_rx.sv
// Directed bench for mii_cmd_rx: frames are built with a byte-wise Ethernet FCS.
module tb_mii_cmd_rx;

  logic        clk;
  logic        rst_n;
  logic [3:0]  mii_D;
  logic        mii_DV;
  logic        mii_ER;
  logic [19:0] command;
  logic [2:0]  opcode;
  logic [7:0]  seqnum;
  logic        strobe;
  logic        tx_strobe;
  logic [15:0] good_count;
  logic [15:0] bad_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fb [0:1599];
  int         fb_len;

  mii_cmd_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mii_D      (mii_D),
    .mii_DV     (mii_DV),
    .mii_ER     (mii_ER),
    .command    (command),
    .opcode     (opcode),
    .seqnum     (seqnum),
    .strobe     (strobe),
    .tx_strobe  (tx_strobe),
    .good_count (good_count),
    .bad_count  (bad_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame of len bytes total, FCS appended low byte first.
  task automatic build(input int len, input logic [47:0] dst, input logic [15:0] typ,
                       input logic [7:0] seq, input logic [7:0] opb,
                       input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    logic [31:0] c;
    logic [47:0] d;
    for (int i = 0; i < len; i++) fb[i] = 8'h00;
    d = dst;
    for (int i = 0; i < 6; i++) begin
      fb[i] = d[47:40];
      d = d << 8;
    end
    for (int i = 6; i < 12; i++) fb[i] = 8'h10 + 8'(i);
    fb[12] = typ[15:8];
    fb[13] = typ[7:0];
    fb[14] = seq;
    fb[15] = opb;
    fb[16] = c0;
    fb[17] = c1;
    fb[18] = c2;
    c = 32'hffffffff;
    for (int i = 0; i < len - 4; i++) begin
      c = c ^ {24'h0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    end
    c = ~c;
    fb[len-4] = c[7:0];
    fb[len-3] = c[15:8];
    fb[len-2] = c[23:16];
    fb[len-1] = c[31:24];
    fb_len = len;
  endtask

  task automatic drive(input logic [3:0] d, input logic er);
    @(negedge clk);
    mii_DV = 1'b1;
    mii_D  = d;
    mii_ER = er;
  endtask

  task automatic send_pre(input int fives);
    repeat (fives) drive(4'h5, 1'b0);
    drive(4'hd, 1'b0);
  endtask

  task automatic send_body(input int from, input int to, input int er_byte);
    logic [7:0] b;
    for (int i = from; i < to; i++) begin
      b = fb[i];
      drive(b[3:0], i == er_byte);
      drive(b[7:4], i == er_byte);
    end
  endtask

  // Ends with time just past the verdict edge (cycle t+1).
  task automatic end_frame();
    @(negedge clk);
    mii_DV = 1'b0;
    mii_ER = 1'b0;
    mii_D  = 4'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_full(input int er_byte, input bit extra);
    send_pre(15);
    send_body(0, fb_len, er_byte);
    if (extra) drive(4'ha, 1'b0);
    end_frame();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " command"}, 32'(command), 32'h0);
    chk({tag, " opcode"}, 32'(opcode), 32'h0);
    chk({tag, " seqnum"}, 32'(seqnum), 32'h0);
    chk({tag, " strobe"}, 32'(strobe), 32'h0);
    chk({tag, " tx_strobe"}, 32'(tx_strobe), 32'h0);
    chk({tag, " good"}, 32'(good_count), 32'h0);
    chk({tag, " bad"}, 32'(bad_count), 32'h0);
  endtask

  localparam logic [47:0] OWN   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;

  initial begin
    rst_n  = 1'b0;
    mii_DV = 1'b0;
    mii_ER = 1'b0;
    mii_D  = 4'h0;
    cycles(3);
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // Minimum-length valid frame; opcode byte upper bits must be ignored.
    build(64, OWN, 16'h5555, 8'h17, 8'hf6, 8'hff, 8'h03, 8'h00);
    send_full(-1, 1'b0);
    chk("A command", 32'(command), 32'h003ff);
    chk("A opcode", 32'(opcode), 32'd6);
    chk("A seqnum", 32'(seqnum), 32'h17);
    chk("A strobe", 32'(strobe), 32'd1);
    chk("A good", 32'(good_count), 32'd1);
    chk("A bad", 32'(bad_count), 32'd0);
    chk("A tx t+1", 32'(tx_strobe), 32'd0);
    cycles(1);
    chk("A tx t+2", 32'(tx_strobe), 32'd0);
    cycles(1);
    chk("A tx t+3", 32'(tx_strobe), 32'd1);

    build(64, OWN, 16'h5555, 8'h22, 8'h01, 8'h11, 8'h22, 8'h03);
    fb[63] = fb[63] ^ 8'h01;
    send_full(-1, 1'b0);
    chk("bad fcs bad", 32'(bad_count), 32'd1);
    build(64, OWN, 16'h0800, 8'h22, 8'h01, 8'h11, 8'h22, 8'h03);
    send_full(-1, 1'b0);
    chk("bad type bad", 32'(bad_count), 32'd2);
    build(64, 48'h02_00_00_00_00_02, 16'h5555, 8'h22, 8'h01, 8'h11, 8'h22, 8'h03);
    send_full(-1, 1'b0);
    chk("bad dst bad", 32'(bad_count), 32'd3);
    chk("rej seqnum", 32'(seqnum), 32'h17);
    chk("rej command", 32'(command), 32'h003ff);
    chk("rej opcode", 32'(opcode), 32'd6);
    chk("rej strobe", 32'(strobe), 32'd1);
    chk("rej good", 32'(good_count), 32'd1);

    build(60, OWN, 16'h5555, 8'h22, 8'h01, 8'h11, 8'h22, 8'h03);
    send_full(-1, 1'b0);
    chk("short bad", 32'(bad_count), 32'd4);
    build(1519, OWN, 16'h5555, 8'h22, 8'h01, 8'h11, 8'h22, 8'h03);
    send_full(-1, 1'b0);
    chk("long bad", 32'(bad_count), 32'd5);
    build(64, OWN, 16'h5555, 8'h22, 8'h01, 8'h11, 8'h22, 8'h03);
    send_full(-1, 1'b1);
    chk("odd bad", 32'(bad_count), 32'd6);
    chk("odd-group good", 32'(good_count), 32'd1);
    chk("odd-group seqnum", 32'(seqnum), 32'h17);

    // Maximum-length frame is still accepted.
    build(1518, OWN, 16'h5555, 8'h81, 8'h03, 8'h01, 8'h02, 8'h03);
    send_full(-1, 1'b0);
    chk("max good", 32'(good_count), 32'd2);
    chk("max command", 32'(command), 32'h30201);
    chk("max opcode", 32'(opcode), 32'd3);
    chk("max seqnum", 32'(seqnum), 32'h81);
    chk("max strobe", 32'(strobe), 32'd0);
    cycles(2);
    chk("max tx", 32'(tx_strobe), 32'd0);

    build(64, OWN, 16'h5555, 8'h44, 8'h02, 8'h55, 8'h66, 8'h07);
    send_full(20, 1'b0);
    chk("er bad", 32'(bad_count), 32'd7);
    chk("er good", 32'(good_count), 32'd2);
    chk("er seqnum", 32'(seqnum), 32'h81);

    // Two broadcast frames separated by a single idle cycle.
    build(64, BCAST, 16'h5555, 8'h91, 8'h01, 8'haa, 8'hbb, 8'hcc);
    send_full(-1, 1'b0);
    chk("b2b1 good", 32'(good_count), 32'd3);
    chk("b2b1 seqnum", 32'(seqnum), 32'h91);
    chk("b2b1 command", 32'(command), 32'hcbbaa);
    chk("b2b1 strobe", 32'(strobe), 32'd1);
    build(64, BCAST, 16'h5555, 8'h92, 8'h05, 8'h11, 8'h22, 8'hff);
    drive(4'h5, 1'b0);
    drive(4'h5, 1'b0);
    chk("b2b1 tx t+2", 32'(tx_strobe), 32'd0);
    drive(4'h5, 1'b0);
    chk("b2b1 tx t+3", 32'(tx_strobe), 32'd1);
    send_pre(12);
    send_body(0, fb_len, -1);
    end_frame();
    chk("b2b2 good", 32'(good_count), 32'd4);
    chk("b2b2 seqnum", 32'(seqnum), 32'h92);
    chk("b2b2 command", 32'(command), 32'hf2211);
    chk("b2b2 opcode", 32'(opcode), 32'd5);
    chk("b2b2 strobe", 32'(strobe), 32'd0);
    chk("b2b2 bad", 32'(bad_count), 32'd7);
    cycles(2);
    chk("b2b2 tx", 32'(tx_strobe), 32'd0);

    // Asynchronous reset in the middle of a frame, released while DV is high.
    build(64, OWN, 16'h5555, 8'h5a, 8'h04, 8'h01, 8'h01, 8'h01);
    send_pre(15);
    send_body(0, 20, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    send_body(20, fb_len, -1);
    end_frame();
    cycles(3);
    chk_zero("after tail");
    build(64, OWN, 16'h5555, 8'h33, 8'h02, 8'h12, 8'h34, 8'h56);
    send_full(-1, 1'b0);
    chk("post good", 32'(good_count), 32'd1);
    chk("post bad", 32'(bad_count), 32'd0);
    chk("post seqnum", 32'(seqnum), 32'h33);
    chk("post command", 32'(command), 32'h63412);
    chk("post opcode", 32'(opcode), 32'd2);
    chk("post strobe", 32'(strobe), 32'd1);

    // good_count wrap from preloaded 0xffff.
    @(negedge clk);
    force dut.good_count = 16'hffff;
    @(negedge clk);
    release dut.good_count;
    send_full(-1, 1'b0);
    chk("wrap good", 32'(good_count), 32'd0);
    chk("wrap strobe", 32'(strobe), 32'd0);
    chk("wrap bad", 32'(bad_count), 32'd0);

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mii_cmd_rx.md
# mii_cmd_rx

Receive-side command parser for the MII link. Nibbles from the PHY are deframed, checked for address, ethertype, length and FCS, and decoded. Each accepted frame's sequence number, opcode and 20-bit command go to the read-out/response stage, along with toggle strobes that start command execution and the reply packet. Rejected frames leave every output except the error counter untouched.

## Interface
- `MAC`, default 48'h02_00_00_00_00_01: unicast address accepted; broadcast ff:ff:ff:ff:ff:ff is also accepted.
- `ETHERTYPE`, default 16'h5555: required type field.
- `clk`  in  1  system clock, one MII nibble per cycle.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `mii_D`  in  4  receive nibble, low nibble of each byte first.
- `mii_DV`  in  1  receive data valid.
- `mii_ER`  in  1  receive error.
- `command`  out  20  last accepted command; reset 0.
- `opcode`  out  3  last accepted opcode; reset 0.
- `seqnum`  out  8  last accepted sequence number; reset 0.
- `strobe`  out  1  toggles once per accepted frame; reset 0.
- `tx_strobe`  out  1  toggles once per accepted frame, after `strobe`; reset 0.
- `good_count`  out  16  accepted frames, wraps modulo 2^16; reset 0.
- `bad_count`  out  16  rejected frames, wraps modulo 2^16; reset 0.

## Operation
- **States:**
  - `WAIT_IDLE` is the reset state. It goes to `IDLE` when `mii_DV`=0. A reset mid-frame therefore discards the rest of that frame.
  - `IDLE` goes to `PRE` on `mii_DV`=1.
  - `PRE`:
    - nibble 5 stays in `PRE`;
    - nibble d after at least one 5 goes to `BODY` and clears the nibble counter and shadow registers;
    - any other nibble goes to `DROP`;
    - `mii_DV` falling in `PRE` returns to `IDLE` with no count.
  - `BODY` collects nibbles until `mii_DV` falls, then performs the verdict and goes to `IDLE`.
  - `DROP` waits for `mii_DV`=0, increments `bad_count` and goes to `IDLE`.
- **`mii_ER`** high in `PRE` or `BODY` goes to `DROP`.
- **Body layout** (bytes after SFD; multi-byte fields are big-endian on the wire, except `command`):
  - bytes 0-5: destination, must equal `MAC` or broadcast;
  - bytes 6-11: source, ignored;
  - bytes 12-13: type, must equal `ETHERTYPE`;
  - byte 14: `seqnum`;
  - byte 15: bits[2:0] are `opcode`, bits[7:3] are ignored;
  - bytes 16-18: `command`, little-endian; bits 23:20 are ignored;
  - remainder: padding, then a 4-byte FCS.
- **Compare flags:** destination and type matches are evaluated on the fly into sticky mismatch flags.
- **Nibble counter:** 12 bits, saturating at 4095.
- **FCS:**
  - reflected CRC-32, polynomial 0xedb88320, 4 bits per cycle, LSB first;
  - register preset to 0xffffffff on SFD;
  - runs over every body nibble including the FCS;
  - passes when the register equals the residue 0xdebb20e3.
- **Verdict:** the frame is accepted only if all of the following hold:
  - no address or type mismatch;
  - FCS passes;
  - nibble count is between 128 and 3036 inclusive (64-1518 bytes);
  - the count is even (a frame ending on an odd nibble is rejected).
- **On accept:**
  - shadow `seqnum`/`opcode`/`command` are copied to the outputs;
  - `strobe` toggles;
  - `good_count` increments.
- **On reject:** `bad_count` increments and nothing else changes.

## Timing
- **Verdict cycle:** let t be the first cycle sampling `mii_DV`=0 after `BODY`. The verdict is computed at t.
  - On accept, `command`/`opcode`/`seqnum`, `strobe` and `good_count` all change at t+1. Data is stable in the same cycle the strobe edge appears, so downstream may sample data on its detected edge.
  - `tx_strobe` toggles at t+3, giving the consumer two cycles to latch addresses before the reply starts.
  - On reject, `bad_count` changes at t+1.
- **Back-to-back frames:** a new frame may start at t+1. The `tx_strobe` pipeline (two flops) must not be disturbed, and the next verdict can be no earlier than t+2+128.
- **Gaps:** minimum inter-frame gap is 1 cycle of `mii_DV`=0.
- **Reset:** asynchronous assertion clears all outputs and state immediately. The first frame is processed only after `mii_DV` has been seen low.

## Structure
- **Package `mii_pkg`:**
  - `CRC_POLY` 32'hedb88320;
  - `CRC_RESIDUE` 32'hdebb20e3;
  - `CRC_INIT`;
  - `MIN_NIBBLES` 128 and `MAX_NIBBLES` 3036;
  - receive state enum `rx_state_t`.
- **Sub-module `mii_crc32`:** one-nibble CRC update with `clear`, `enable` and `data[3:0]` inputs and a `crc[31:0]` output. It is shareable with the transmit path.
- **Top module:** FSM, nibble counter, byte assembler (low nibble held, byte completes on odd nibble), field capture keyed on byte index, verdict logic, counters and strobe pipeline.

## Test plan
- Valid 64-byte frame to `MAC` with seq 0x17, opcode 6, command bytes ff 03 00 and correct FCS -> at t+1 `command`=20'h003ff, `opcode`=6, `seqnum`=8'h17, `strobe` toggled once, `good_count`=1; at t+3 `tx_strobe` toggled.
- Same frame with one FCS bit flipped, another with type 0x0800, another to MAC 02:00:00:00:00:02 -> `bad_count`=3, `strobe` unchanged, outputs unchanged.
- 60-byte frame with valid FCS, 1519-byte frame, and frame ending on an odd nibble -> each rejected, `bad_count`+1.
- `mii_ER` pulsed at byte 20 of an otherwise valid frame -> rejected once when `mii_DV` falls. Two valid broadcast frames with a 1-cycle gap -> both accepted, `strobe` and `tx_strobe` each toggle twice.
- `rst_n` asserted mid-frame and released while `mii_DV`=1 -> all outputs 0 immediately; the remainder of that frame is ignored (no counter change); the next valid frame is accepted.
- 65535 good frames followed by one more (counter preload via force allowed) -> `good_count` wraps to 0.
